// File: rtl/matmul_controller.sv
// -----------------------------------------------------------------------------
// matmul_controller
//
// Sequencer for a small (up to MAX_DIM x MAX_DIM) matrix-multiply datapath.
// A start pulse latches the dimensions of W (row_w x col_w) and X
// (row_x x col_x), which are then validated. A legal job streams all of W and
// then all of X, row-major, over a valid/ready handshake into the datapath
// write port. It then sweeps the multiply-accumulate schedule (i outer,
// j middle, k inner) and pulses done. An illegal job pulses done with the
// sticky err flag set, and issues no writes and no MAC strobes.
//
// Optional feature (macro MMC_MEM_CLEAR_EN): a legal job first zero-fills
// every W and X location (W first, then X, row-major) before loading, so the
// unused entries of a smaller matrix read as zero.
//
// Ports:
//   clk          rising-edge clock
//   clear_mem_n  asynchronous active-low reset
//   start        one-cycle pulse; latches dims and begins a job (IDLE only)
//   row_w/col_w  W dimensions
//   row_x/col_x  X dimensions
//   in_valid     data_in holds an element
//   in_ready     the controller accepts an element this cycle
//   data_in      element stream, row-major, all of W then all of X
//   wr_en        datapath element write strobe (one cycle after acceptance)
//   wr_sel       0 = W memory, 1 = X memory
//   wr_row/col   0-based write address
//   wr_data      registered copy of the accepted element
//   mac_clr      clear accumulator (mac_i, mac_j) before its first product
//   mac_en       accumulate W[mac_i][mac_k] * X[mac_k][mac_j]
//   mac_i/j/k    registered loop indices
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse (success or error)
//   err          sticky dimension error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module matmul_controller #(
  parameter int DATA_W  = 4,
  parameter int DIM_W   = 2,
  parameter int MAX_DIM = 3
) (
  input  logic              clk,
  input  logic              clear_mem_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  row_w,
  input  logic [DIM_W-1:0]  col_w,
  input  logic [DIM_W-1:0]  row_x,
  input  logic [DIM_W-1:0]  col_x,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [DIM_W-1:0]  wr_row,
  output logic [DIM_W-1:0]  wr_col,
  output logic [DATA_W-1:0] wr_data,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [DIM_W-1:0]  mac_i,
  output logic [DIM_W-1:0]  mac_j,
  output logic [DIM_W-1:0]  mac_k,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);
`ifdef MMC_MEM_CLEAR_EN
  localparam logic [DIM_W-1:0] LAST_IDX = DIM_W'(MAX_DIM - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
`ifdef MMC_MEM_CLEAR_EN
    CLEAR,
`endif
    LOAD_W,
    LOAD_X,
    COMPUTE,
    FINISH,
    ERROR
  } state_t;

  state_t state, next_state;

  // Dimensions latched at start; every comparison uses these, never the
  // live inputs, so dims changing mid-job have no effect.
  logic [DIM_W-1:0] rw_q, cw_q, rx_q, cx_q;

  // Load-phase address counters (also reused by the zero-fill sweep).
  logic [DIM_W-1:0] ld_row, ld_col;
`ifdef MMC_MEM_CLEAR_EN
  logic             clr_sel;
`endif

  // Set by the last X beat: LOAD_X holds one more cycle (in_ready low) so
  // that the final element write lands before the first MAC cycle.
  logic             x_done;

  logic accept, dims_bad, w_last, x_last, mac_last;

  function automatic logic dim_bad(input logic [DIM_W-1:0] d);
    return (d == '0) || (int'(d) > MAX_DIM);
  endfunction

  assign dims_bad = dim_bad(rw_q) || dim_bad(cw_q) || dim_bad(rx_q) ||
                    dim_bad(cx_q) || (cw_q != rx_q);

  assign w_last   = (ld_row == rw_q - ONE) && (ld_col == cw_q - ONE);
  assign x_last   = (ld_row == rx_q - ONE) && (ld_col == cx_q - ONE);
  assign mac_last = (mac_i == rw_q - ONE) && (mac_j == cx_q - ONE) &&
                    (mac_k == cw_q - ONE);

  assign in_ready = (state == LOAD_W) || ((state == LOAD_X) && !x_done);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH) || (state == ERROR);
  assign mac_en   = (state == COMPUTE);
  assign mac_clr  = mac_en && (mac_k == '0);

  // State register.
  always_ff @(posedge clk or negedge clear_mem_n) begin
    if (!clear_mem_n) state <= IDLE;
    else              state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so
    // no latch is inferred when a branch leaves next_state untouched.
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CHECK;
`ifdef MMC_MEM_CLEAR_EN
      CHECK:   next_state = dims_bad ? ERROR : CLEAR;
      CLEAR:   if (clr_sel && (ld_row == LAST_IDX) && (ld_col == LAST_IDX))
                 next_state = LOAD_W;
`else
      CHECK:   next_state = dims_bad ? ERROR : LOAD_W;
`endif
      LOAD_W:  if (accept && w_last) next_state = LOAD_X;
      LOAD_X:  if (x_done) next_state = COMPUTE;
      COMPUTE: if (mac_last) next_state = FINISH;
      FINISH:  next_state = IDLE;
      ERROR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latched dims, counters, registered write port, err flag.
  always_ff @(posedge clk or negedge clear_mem_n) begin
    // NOTE: every register here, outputs included, is cleared by the async
    // reset, so an abort silences wr_en and mac strobes in the same cycle.
    if (!clear_mem_n) begin
      rw_q    <= '0;
      cw_q    <= '0;
      rx_q    <= '0;
      cx_q    <= '0;
      ld_row  <= '0;
      ld_col  <= '0;
`ifdef MMC_MEM_CLEAR_EN
      clr_sel <= 1'b0;
`endif
      x_done  <= 1'b0;
      mac_i   <= '0;
      mac_j   <= '0;
      mac_k   <= '0;
      wr_en   <= 1'b0;
      wr_sel  <= 1'b0;
      wr_row  <= '0;
      wr_col  <= '0;
      wr_data <= '0;
      err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read below sees
      // the pre-edge counter values (the write address is pre-increment).
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          ld_row  <= '0;
          ld_col  <= '0;
`ifdef MMC_MEM_CLEAR_EN
          clr_sel <= 1'b0;
`endif
          x_done  <= 1'b0;
          mac_i   <= '0;
          mac_j   <= '0;
          mac_k   <= '0;
          if (start) begin
            rw_q <= row_w;
            cw_q <= col_w;
            rx_q <= row_x;
            cx_q <= col_x;
            err  <= 1'b0;
          end
        end

        // err rises together with the ERROR cycle's done pulse.
        CHECK: if (dims_bad) err <= 1'b1;

`ifdef MMC_MEM_CLEAR_EN
        // Zero-fill sweep: W then X, each MAX_DIM x MAX_DIM, row-major. The
        // counters wrap back to zero on the final location.
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_sel  <= clr_sel;
          wr_row  <= ld_row;
          wr_col  <= ld_col;
          wr_data <= '0;
          if (ld_col == LAST_IDX) begin
            ld_col <= '0;
            if (ld_row == LAST_IDX) begin
              ld_row  <= '0;
              clr_sel <= ~clr_sel;
            end else begin
              ld_row <= ld_row + ONE;
            end
          end else begin
            ld_col <= ld_col + ONE;
          end
        end
`endif

        LOAD_W: if (accept) begin
          wr_en   <= 1'b1;
          wr_sel  <= 1'b0;
          wr_row  <= ld_row;
          wr_col  <= ld_col;
          wr_data <= data_in;
          if (ld_col == cw_q - ONE) begin
            ld_col <= '0;
            ld_row <= w_last ? '0 : ld_row + ONE;
          end else begin
            ld_col <= ld_col + ONE;
          end
        end

        LOAD_X: if (accept) begin
          wr_en   <= 1'b1;
          wr_sel  <= 1'b1;
          wr_row  <= ld_row;
          wr_col  <= ld_col;
          wr_data <= data_in;
          x_done  <= x_last;
          if (ld_col == cx_q - ONE) begin
            ld_col <= '0;
            ld_row <= x_last ? '0 : ld_row + ONE;
          end else begin
            ld_col <= ld_col + ONE;
          end
        end

        // k inner, j middle, i outer; all indices return to zero at the end.
        COMPUTE: begin
          if (mac_k == cw_q - ONE) begin
            mac_k <= '0;
            if (mac_j == cx_q - ONE) begin
              mac_j <= '0;
              mac_i <= mac_last ? '0 : mac_i + ONE;
            end else begin
              mac_j <= mac_j + ONE;
            end
          end else begin
            mac_k <= mac_k + ONE;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_controller.sv
// -----------------------------------------------------------------------------
// tb_matmul_controller
//
// Self-checking bench for matmul_controller. Directed jobs from the test plan
// are followed by a run of random back-to-back jobs. A negedge monitor
// records every write, MAC strobe and done pulse; each job is then compared
// against a reference built from the matrix shapes alone (expected write
// list, expected i/j/k sweep, completion timing). Under MMC_MEM_CLEAR_EN the
// reference prepends the 18-location zero-fill.
// -----------------------------------------------------------------------------
module tb_matmul_controller;

  localparam int DATA_W  = 4;
  localparam int DIM_W   = 2;
  localparam int MAX_DIM = 3;
`ifdef MMC_MEM_CLEAR_EN
  localparam int CLEAR_WRITES = 2 * MAX_DIM * MAX_DIM;
`else
  localparam int CLEAR_WRITES = 0;
`endif

  logic              clk = 1'b0;
  logic              clear_mem_n;
  logic              start;
  logic [DIM_W-1:0]  row_w, col_w, row_x, col_x;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              wr_en, wr_sel;
  logic [DIM_W-1:0]  wr_row, wr_col;
  logic [DATA_W-1:0] wr_data;
  logic              mac_clr, mac_en;
  logic [DIM_W-1:0]  mac_i, mac_j, mac_k;
  logic              busy, done, err;

  matmul_controller #(.DATA_W(DATA_W), .DIM_W(DIM_W), .MAX_DIM(MAX_DIM)) dut (
    .clk(clk), .clear_mem_n(clear_mem_n), .start(start),
    .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
    .wr_data(wr_data), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_i(mac_i), .mac_j(mac_j), .mac_k(mac_k),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [21:0] out_vec;
  assign out_vec = {in_ready, wr_en, wr_sel, wr_row, wr_col, wr_data, mac_clr,
                    mac_en, mac_i, mac_j, mac_k, busy, done, err};

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int enc(input int a, input int b, input int c, input int d);
    return ((a * 16 + b) * 16 + c) * 16 + d;
  endfunction

  // ---------------- monitor ----------------
  typedef struct { int val; int cyc; } ev_t;
  ev_t wr_q[$];
  ev_t mac_q[$];
  int  done_cyc_q[$];
  int  err_at_done;
  int  rdy_cnt;
  int  first_rdy_cyc;
  int  cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (wr_en)
      wr_q.push_back('{enc(int'(wr_sel), int'(wr_row), int'(wr_col), int'(wr_data)), cyc});
    if (mac_en)
      mac_q.push_back('{enc(int'(mac_clr), int'(mac_i), int'(mac_j), int'(mac_k)), cyc});
    if (done) begin
      done_cyc_q.push_back(cyc);
      err_at_done = int'(err);
    end
    if (in_ready) begin
      rdy_cnt++;
      if (first_rdy_cyc < 0) first_rdy_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int stim_q[$];   // optional fixed data for the next job; random otherwise

  // One job: start pulse, stream (mode 0 = always valid, 1 = toggle 1,0,..,
  // 2 = random), wait for done, then compare against the shape-based model.
  task automatic run_job(input int rw, input int cw, input int rx, input int cx,
                         input int mode, input bit poke, input string tag);
    int  data_q[$];
    int  exp_w[$];
    int  n, idx, budget, start_cyc, clr_cnt;
    bit  bad, tog, poked;
    bad = (rw == 0) || (cw == 0) || (rx == 0) || (cx == 0) || (cw != rx);
    n   = bad ? 0 : rw * cw + rx * cx;
    data_q = stim_q;
    stim_q.delete();
    while (data_q.size() < n) data_q.push_back(int'($urandom_range(0, (1 << DATA_W) - 1)));

    wr_q.delete(); mac_q.delete(); done_cyc_q.delete();
    rdy_cnt = 0; first_rdy_cyc = -1; err_at_done = -1;

    row_w = DIM_W'(rw); col_w = DIM_W'(cw); row_x = DIM_W'(rx); col_x = DIM_W'(cx);
    in_valid  = 1'b0;
    start     = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;

    idx = 0; budget = 0; tog = 1'b1;
    while (idx < n && budget < 400) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       begin in_valid = tog; tog = !tog; end
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      data_in = DATA_W'(data_q[idx]);
      row_w = DIM_W'($urandom); col_w = DIM_W'($urandom);
      row_x = DIM_W'($urandom); col_x = DIM_W'($urandom);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      budget++;
    end
    check({tag, "_beats"}, idx, n);

    // Garbage stays valid afterwards: it must never be accepted.
    budget = 0; poked = 1'b0;
    while (done_cyc_q.size() == 0 && budget < 200) begin
      in_valid = 1'b1;
      data_in  = DATA_W'($urandom);
      start    = 1'b0;
      if (poke && !poked && mac_q.size() > 0) begin
        start = 1'b1; poked = 1'b1;
        row_w = '0; col_w = 2'd2; row_x = 2'd3; col_x = '0;
      end
      @(posedge clk); #1;
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check({tag, "_done_cnt"}, done_cyc_q.size(), 1);

    if (bad) begin
      check({tag, "_err_at_done"}, err_at_done, 1);
      check({tag, "_err_sticky"}, int'(err), 1);
      check({tag, "_done_lat"}, (done_cyc_q.size() > 0) ? done_cyc_q[0] - start_cyc : -1, 2);
      check({tag, "_wr_cnt"}, wr_q.size(), 0);
      check({tag, "_mac_cnt"}, mac_q.size(), 0);
      check({tag, "_rdy_cnt"}, rdy_cnt, 0);
    end else begin
      for (int c = 0; c < CLEAR_WRITES; c++)
        exp_w.push_back(enc(c / (MAX_DIM * MAX_DIM), (c % (MAX_DIM * MAX_DIM)) / MAX_DIM,
                            c % MAX_DIM, 0));
      for (int r = 0; r < rw; r++)
        for (int c = 0; c < cw; c++) exp_w.push_back(enc(0, r, c, data_q[r * cw + c]));
      for (int r = 0; r < rx; r++)
        for (int c = 0; c < cx; c++) exp_w.push_back(enc(1, r, c, data_q[rw * cw + r * cx + c]));
      check({tag, "_wr_cnt"}, wr_q.size(), exp_w.size());
      for (int e = 0; e < exp_w.size() && e < wr_q.size(); e++)
        check($sformatf("%s_wr%0d", tag, e), wr_q[e].val, exp_w[e]);
`ifdef MMC_MEM_CLEAR_EN
      if (wr_q.size() >= CLEAR_WRITES)
        check({tag, "_rdy_after_clear"}, int'(first_rdy_cyc >= wr_q[CLEAR_WRITES-1].cyc), 1);
`endif

      // Reference sweep: i outer, j middle, k inner; clear on k == 0.
      check({tag, "_mac_cnt"}, mac_q.size(), rw * cx * cw);
      idx = 0; clr_cnt = 0;
      for (int i = 0; i < rw; i++)
        for (int j = 0; j < cx; j++)
          for (int k = 0; k < cw; k++) begin
            if (idx < mac_q.size()) begin
              check($sformatf("%s_mac%0d", tag, idx), mac_q[idx].val, enc(int'(k == 0), i, j, k));
              clr_cnt += mac_q[idx].val / 4096;
            end
            idx++;
          end
      check({tag, "_clr_cnt"}, clr_cnt, rw * cx);
      if (mac_q.size() > 0 && wr_q.size() > 0) begin
        check({tag, "_mac_contig"}, mac_q[mac_q.size()-1].cyc - mac_q[0].cyc + 1, mac_q.size());
        check({tag, "_mac_after_wr"}, int'(mac_q[0].cyc > wr_q[wr_q.size()-1].cyc), 1);
        check({tag, "_done_after_mac"},
              (done_cyc_q.size() > 0) ? done_cyc_q[0] - mac_q[mac_q.size()-1].cyc : -1, 1);
      end
      check({tag, "_err_at_done"}, err_at_done, 0);
      check({tag, "_busy_after"}, int'(busy), 0);
      if (mode == 0) check({tag, "_rdy_cnt"}, rdy_cnt, n);
    end

    if (poke) begin
      repeat (3) begin @(posedge clk); #1; end
      check({tag, "_poke_busy"}, int'(busy), 0);
      check({tag, "_poke_done"}, done_cyc_q.size(), 1);
      check({tag, "_poke_err"}, int'(err), 0);
    end
  endtask

  initial begin
    int rw, cw, rx, cx, beats;

    clear_mem_n = 1'b0; start = 1'b0; in_valid = 1'b0; data_in = '0;
    row_w = '0; col_w = '0; row_x = '0; col_x = '0;

    // Reset held over start / in_valid activity.
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'($urandom_range(0, 1)); in_valid = 1'b1; data_in = DATA_W'($urandom);
      row_w = 2'd2; col_w = 2'd2; row_x = 2'd2; col_x = 2'd2;
    end
    #2 check("rst_hold_outputs", int'(out_vec), 0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    clear_mem_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted mid-load.
    row_w = 2'd3; col_w = 2'd3; row_x = 2'd3; col_x = 2'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0;
    for (int t = 0; t < 60 && beats < 2; t++) begin
      in_valid = 1'b1; data_in = DATA_W'(t + 1);
      if (in_ready) beats++;
      @(posedge clk); #1;
    end
    check("rst_mid_beats", beats, 2);
    #2 clear_mem_n = 1'b0;
    #1 check("rst_mid_outputs", int'(out_vec), 0);
    wr_q.delete(); mac_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    clear_mem_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("rst_mid_no_wr", wr_q.size(), 0);
    check("rst_mid_no_mac", mac_q.size(), 0);
    check("rst_mid_idle", int'(busy), 0);

    // Legal 3x2 * 2x3 job, free-flowing then with toggled in_valid.
    stim_q = '{1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    run_job(3, 2, 2, 3, 0, 1'b0, "legal");
    stim_q = '{1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
    run_job(3, 2, 2, 3, 1, 1'b0, "stall");

    // Inner-dimension mismatch and zero dims.
    run_job(2, 2, 3, 2, 0, 1'b0, "mismatch");
    run_job(0, 2, 2, 2, 0, 1'b0, "zero_rw");
    run_job(2, 2, 2, 0, 0, 1'b0, "zero_cx");

    // 1x1 * 1x1 corner, then start pulsed during COMPUTE.
    stim_q = '{5, 7};
    run_job(1, 1, 1, 1, 0, 1'b0, "one");
    run_job(2, 3, 3, 2, 2, 1'b1, "poke");

    // Random back-to-back jobs, legal and illegal.
    for (int j = 0; j < 12; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        do begin
          rw = int'($urandom_range(0, 3)); cw = int'($urandom_range(0, 3));
          rx = int'($urandom_range(0, 3)); cx = int'($urandom_range(0, 3));
        end while (rw != 0 && cw != 0 && rx != 0 && cx != 0 && cw == rx);
      end else begin
        rw = int'($urandom_range(1, 3)); cw = int'($urandom_range(1, 3));
        rx = cw;                         cx = int'($urandom_range(1, 3));
      end
      run_job(rw, cw, rx, cx, int'($urandom_range(0, 2)), 1'b0, $sformatf("rnd%0d", j));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matmul_controller.md
Name: matmul_controller

Overview:
- Sequencer for the 3x3-max matrix-multiply datapath.
- Accepts dimensions and a start pulse, then validates W(row_w x col_w) * X(row_x x col_x).
- Accepts the serial element stream over a valid/ready handshake and drives the datapath write port.
- Schedules the multiply-accumulate sweep and reports done/err; replaces hand-sequenced stimulus on the datapath's data_in.

Parameters:
- DATA_W, 4, element width on data_in/wr_data.
- DIM_W, 2, width of dimension and index fields.
- MAX_DIM, 3, largest legal row/column count.

Ports:
- clk  in  1  rising-edge clock
- clear_mem_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches dims, begins job
- row_w  in  DIM_W  W rows
- col_w  in  DIM_W  W columns
- row_x  in  DIM_W  X rows
- col_x  in  DIM_W  X columns
- in_valid  in  1  data_in holds an element
- in_ready  out  1  controller accepts element this cycle
- data_in  in  DATA_W  element, row-major, all of W then all of X
- wr_en  out  1  datapath element write strobe
- wr_sel  out  1  0 = W memory, 1 = X memory
- wr_row  out  DIM_W  0-based write row
- wr_col  out  DIM_W  0-based write column
- wr_data  out  DATA_W  registered copy of accepted element
- mac_clr  out  1  clear accumulator (i,j) before first product
- mac_en  out  1  accumulate W[i][k]*X[k][j] into (i,j)
- mac_i  out  DIM_W  output row index
- mac_j  out  DIM_W  output column index
- mac_k  out  DIM_W  inner index
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse, job complete
- err  out  1  sticky dimension error, cleared by next start

Behaviour:
- Reset: all outputs 0, FSM = IDLE, latched dims 0. Reset mid-job aborts immediately; no further writes or MAC strobes.
- FSM states: IDLE, CHECK, LOAD_W, LOAD_X, COMPUTE, FINISH, ERROR.
- IDLE: start=1 latches the four dims, clears err, goes to CHECK. start while busy is ignored.
- CHECK (1 cycle): error if any dim = 0, any dim > MAX_DIM, or col_w != row_x. Error -> ERROR; otherwise -> LOAD_W.
- ERROR (1 cycle): sets err=1, pulses done, -> IDLE. No wr_en or mac_en is issued.
- LOAD_W / LOAD_X: in_ready=1. A beat is accepted when in_valid & in_ready.
  - Each accepted beat produces wr_en=1 on the next cycle, with wr_data = beat and row/col from the pre-increment counters (1-cycle latency).
  - Column counter wraps at col-1 and increments the row counter.
  - The last W beat (row_w-1, col_w-1) moves to LOAD_X with counters zeroed. The last X beat moves to COMPUTE.
  - in_ready drops in the cycle after the last X beat; in_valid is ignored outside the LOAD states.
- COMPUTE: mac_en=1 every cycle.
  - Nested loop order: i outer, j middle, k inner, with k in 0..col_w-1.
  - mac_clr=1 exactly when k=0. Indices are registered outputs.
  - After i=row_w-1, j=col_x-1, k=col_w-1 -> FINISH.
  - COMPUTE lasts row_w*col_x*col_w cycles.
  - The first COMPUTE cycle follows the last wr_en, so the datapath never reads a stale element.
- FINISH: done=1 for one cycle, -> IDLE. busy falls in the same cycle that IDLE is entered.
- Back-to-back: start in the cycle after done is accepted.
- Arithmetic: all counters DIM_W wide and compared against latched dims, never against live inputs. Dims changing mid-job have no effect.

Optional Feature:
- Macro: MMC_MEM_CLEAR_EN.
- Defined: CHECK success goes to CLEAR instead of LOAD_W.
  - CLEAR issues wr_en with wr_data=0 for all MAX_DIM*MAX_DIM locations of W, then X: wr_sel 0 then 1, row-major, 18 cycles at defaults.
  - in_ready=0 during CLEAR; CLEAR then -> LOAD_W. Unused entries of smaller matrices read zero.
- Undefined: CLEAR state is absent; CHECK -> LOAD_W directly.

Test Plan:
- Reset: hold clear_mem_n=0 over start/in_valid activity -> all outputs 0. Deassert, then assert mid-LOAD_W -> outputs 0 the same cycle, FSM in IDLE.
- Legal job: row_w=3, col_w=2, row_x=2, col_x=3; stream 1,3,4,5,6,7,8,9,10,11,12,13 with in_valid=1.
  - Writes: W(0,0)=1 … W(2,1)=7, then X(0,0)=8 … X(1,2)=13.
  - Then 18 mac_en cycles, 9 mac_clr pulses, done once, err=0.
- Handshake stalls: same job with in_valid toggled 1,0,1,0 -> exactly 12 wr_en pulses with identical addresses/data; no write on in_valid=0 cycles.
- Mismatch: col_w=2, row_x=3 -> err=1, done pulses 2 cycles after start, zero wr_en/mac_en, in_ready never high.
- Corners:
  - 1x1 * 1x1 with data 5,7 -> two writes, one COMPUTE cycle with mac_clr=mac_en=1 at (0,0,0).
  - Any dim=0 -> err.
  - start during COMPUTE -> ignored.
- MMC_MEM_CLEAR_EN defined: 2x2*2x2 job -> 18 zero writes precede the first data write; in_ready stays 0 for those cycles.
